// File: rtl/axi_lite_arb_pkg.sv
// rtl/axi_lite_arb_pkg.sv - state encodings, response codes and index-width helper for the arbiter
package axi_lite_arb_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_AW_W = 3'd1;
  localparam logic [2:0] ST_WR_B    = 3'd2;
  localparam logic [2:0] ST_RD_AR   = 3'd3;
  localparam logic [2:0] ST_RD_R    = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Never returns less than 1 so a two-requester index still has a bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/axi_lite_master_arbiter_if.sv
// rtl/axi_lite_master_arbiter_if.sv - requester-side and AXI4-Lite master signals of the arbiter
interface axi_lite_master_arbiter_if #(
  parameter int NUM_REQ         = 4,
  parameter int AXIS_ADDR_WIDTH = 6,
  parameter int AXIS_DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 req_write;
  logic [NUM_REQ*AXIS_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*AXIS_DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [AXIS_DATA_WIDTH-1:0]         rsp_rdata;
  logic [1:0]                         rsp_resp;
  logic                               busy;

  logic [AXIS_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [2:0]                   M_AXI_AWPROT;
  logic                         M_AXI_AWVALID;
  logic                         M_AXI_AWREADY;
  logic [AXIS_DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [AXIS_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                         M_AXI_WVALID;
  logic                         M_AXI_WREADY;
  logic [1:0]                   M_AXI_BRESP;
  logic                         M_AXI_BVALID;
  logic                         M_AXI_BREADY;
  logic [AXIS_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic [2:0]                   M_AXI_ARPROT;
  logic                         M_AXI_ARVALID;
  logic                         M_AXI_ARREADY;
  logic [AXIS_DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]                   M_AXI_RRESP;
  logic                         M_AXI_RVALID;
  logic                         M_AXI_RREADY;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_resp, busy,
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, input M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_resp, busy,
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

// File: rtl/round_robin_arbiter.sv
// rtl/round_robin_arbiter.sv - round-robin grant search with an internal priority pointer
module round_robin_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  // Scan from the pointer upwards, wrapping, and keep the first requester found.
  always_comb begin
    w_found     = 1'b0;
    o_grant_idx = '0;
    w_cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = IDX_W'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found     = 1'b1;
        o_grant_idx = w_cand;
      end
    end
  end

  assign o_grant = w_found ? (NUM_REQ'(1) << o_grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_enable && w_found) begin
      r_ptr <= (o_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : o_grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/axi_lite_master_arbiter.sv
// rtl/axi_lite_master_arbiter.sv - shares one AXI4-Lite master among NUM_REQ requesters, one transaction at a time
module axi_lite_master_arbiter
  import axi_lite_arb_pkg::*;
#(
  parameter  int NUM_REQ         = 4,
  parameter  int AXIS_ADDR_WIDTH = 6,
  parameter  int AXIS_DATA_WIDTH = 32,
  localparam int IDX_W           = clog2(NUM_REQ)
) (
  input logic                       clk,
  input logic                       reset,
  axi_lite_master_arbiter_if.master bus
);
  logic [2:0]                 r_state;
  logic [2:0]                 w_state_nxt;
  logic [NUM_REQ-1:0]         w_grant;
  logic [IDX_W-1:0]           w_grant_idx;
  logic                       w_accept;
  logic [AXIS_ADDR_WIDTH-1:0] r_addr;
  logic [AXIS_DATA_WIDTH-1:0] r_wdata;
  logic [IDX_W-1:0]           r_gidx;
  logic                       r_aw_done;
  logic                       r_w_done;
  logic [NUM_REQ-1:0]         r_rsp_valid;
  logic [AXIS_DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]                 r_rsp_resp;
  logic                       w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  assign w_accept = (r_state == ST_IDLE) && (|bus.req_valid) && !reset;

  round_robin_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk         (clk),
    .reset       (reset),
    .i_req       (bus.req_valid),
    .i_enable    (w_accept),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign w_aw_hs = (r_state == ST_WR_AW_W) && !r_aw_done && bus.M_AXI_AWREADY;
  assign w_w_hs  = (r_state == ST_WR_AW_W) && !r_w_done && bus.M_AXI_WREADY;
  assign w_b_hs  = (r_state == ST_WR_B) && bus.M_AXI_BVALID;
  assign w_ar_hs = (r_state == ST_RD_AR) && bus.M_AXI_ARREADY;
  assign w_r_hs  = (r_state == ST_RD_R) && bus.M_AXI_RVALID;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_state_nxt = bus.req_write[w_grant_idx] ? ST_WR_AW_W : ST_RD_AR;
      ST_WR_AW_W: if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_nxt = ST_WR_B;
      ST_WR_B:    if (w_b_hs) w_state_nxt = ST_IDLE;
      ST_RD_AR:   if (w_ar_hs) w_state_nxt = ST_RD_R;
      ST_RD_R:    if (w_r_hs) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Completion registers the response so rsp_valid lands in the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_gidx      <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= RESP_OKAY;
    end else begin
      r_rsp_valid <= '0;
      if (w_accept) begin
        r_addr    <= bus.req_addr[w_grant_idx*AXIS_ADDR_WIDTH +: AXIS_ADDR_WIDTH];
        r_wdata   <= bus.req_wdata[w_grant_idx*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
        r_gidx    <= w_grant_idx;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (w_b_hs) begin
        r_rsp_valid <= NUM_REQ'(1) << r_gidx;
        r_rsp_rdata <= '0;
        r_rsp_resp  <= bus.M_AXI_BRESP;
      end
      if (w_r_hs) begin
        r_rsp_valid <= NUM_REQ'(1) << r_gidx;
        r_rsp_rdata <= bus.M_AXI_RDATA;
        r_rsp_resp  <= bus.M_AXI_RRESP;
      end
    end
  end

  always_comb begin
    bus.req_ready     = w_accept ? w_grant : '0;
    bus.M_AXI_AWVALID = (r_state == ST_WR_AW_W) && !r_aw_done;
    bus.M_AXI_WVALID  = (r_state == ST_WR_AW_W) && !r_w_done;
    bus.M_AXI_BREADY  = (r_state == ST_WR_B);
    bus.M_AXI_ARVALID = (r_state == ST_RD_AR);
    bus.M_AXI_RREADY  = (r_state == ST_RD_R);
    bus.busy          = (r_state != ST_IDLE);
  end

  assign bus.M_AXI_AWADDR = r_addr;
  assign bus.M_AXI_ARADDR = r_addr;
  assign bus.M_AXI_WDATA  = r_wdata;
  assign bus.M_AXI_WSTRB  = '1;
  assign bus.M_AXI_AWPROT = 3'b000;
  assign bus.M_AXI_ARPROT = 3'b000;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = r_rsp_rdata;
  assign bus.rsp_resp     = r_rsp_resp;
endmodule

// File: tb/tb_axi_lite_master_arbiter.sv
// tb/tb_axi_lite_master_arbiter.sv - directed self-checking bench for the AXI-Lite master arbiter
module tb_axi_lite_master_arbiter;
  import axi_lite_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 6;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  axi_lite_master_arbiter_if #(.NUM_REQ(N), .AXIS_ADDR_WIDTH(AW), .AXIS_DATA_WIDTH(DW)) bus ();

  axi_lite_master_arbiter #(.NUM_REQ(N), .AXIS_ADDR_WIDTH(AW), .AXIS_DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: each READY/VALID answers after a configurable number of wait cycles.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [1:0]    bresp_cfg = RESP_OKAY;
  logic [1:0]    rresp_cfg = RESP_OKAY;
  logic [DW-1:0] rdata_cfg = '0;

  always @(posedge clk) begin
    #1;
    bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && (aw_cnt >= aw_dly);
    aw_cnt = !bus.M_AXI_AWVALID ? 0 : (bus.M_AXI_AWREADY ? aw_cnt : aw_cnt + 1);
    bus.M_AXI_WREADY = bus.M_AXI_WVALID && (w_cnt >= w_dly);
    w_cnt = !bus.M_AXI_WVALID ? 0 : (bus.M_AXI_WREADY ? w_cnt : w_cnt + 1);
    bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && (ar_cnt >= ar_dly);
    ar_cnt = !bus.M_AXI_ARVALID ? 0 : (bus.M_AXI_ARREADY ? ar_cnt : ar_cnt + 1);
    bus.M_AXI_BVALID = bus.M_AXI_BREADY && (b_cnt >= b_dly);
    b_cnt = !bus.M_AXI_BREADY ? 0 : (bus.M_AXI_BVALID ? b_cnt : b_cnt + 1);
    bus.M_AXI_BRESP = bus.M_AXI_BVALID ? bresp_cfg : 2'b00;
    bus.M_AXI_RVALID = bus.M_AXI_RREADY && (r_cnt >= r_dly);
    r_cnt = !bus.M_AXI_RREADY ? 0 : (bus.M_AXI_RVALID ? r_cnt : r_cnt + 1);
    bus.M_AXI_RRESP = bus.M_AXI_RVALID ? rresp_cfg : 2'b00;
    bus.M_AXI_RDATA = bus.M_AXI_RVALID ? rdata_cfg : '0;
  end

  logic [N-1:0] g_vec[$];
  int           g_cyc[$];
  int           aw_hs = 0, w_hs = 0, b_hs = 0, rsp_n = 0, proto_err = 0;
  int           aw_cyc = 0, w_cyc = 0, b_cyc = 0, rsp_cyc = 0;
  logic [AW-1:0] aw_addr, ar_addr, p_awaddr, p_araddr;
  logic [DW-1:0] w_data, rsp_data, p_wdata;
  logic [3:0]    w_strb;
  logic [N-1:0]  rsp_vec;
  logic [1:0]    rsp_resp_s;
  logic          p_rst = 1'b1, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;

  always @(negedge clk) begin
    if (|bus.req_ready) begin
      g_vec.push_back(bus.req_ready);
      g_cyc.push_back(cyc);
    end
    if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
      aw_hs++; aw_cyc = cyc; aw_addr = bus.M_AXI_AWADDR;
    end
    if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
      w_hs++; w_cyc = cyc; w_data = bus.M_AXI_WDATA; w_strb = bus.M_AXI_WSTRB;
    end
    if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin
      b_hs++; b_cyc = cyc;
    end
    if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) ar_addr = bus.M_AXI_ARADDR;
    if (|bus.rsp_valid) begin
      rsp_n++; rsp_cyc = cyc; rsp_vec = bus.rsp_valid;
      rsp_data = bus.rsp_rdata; rsp_resp_s = bus.rsp_resp;
    end
    if (!p_rst) begin
      if (p_awv && !p_awr && (!bus.M_AXI_AWVALID || bus.M_AXI_AWADDR !== p_awaddr)) proto_err++;
      if (p_wv && !p_wr && (!bus.M_AXI_WVALID || bus.M_AXI_WDATA !== p_wdata)) proto_err++;
      if (p_arv && !p_arr && (!bus.M_AXI_ARVALID || bus.M_AXI_ARADDR !== p_araddr)) proto_err++;
    end
    p_rst = reset;
    p_awv = bus.M_AXI_AWVALID; p_awr = bus.M_AXI_AWREADY; p_awaddr = bus.M_AXI_AWADDR;
    p_wv = bus.M_AXI_WVALID;   p_wr = bus.M_AXI_WREADY;   p_wdata = bus.M_AXI_WDATA;
    p_arv = bus.M_AXI_ARVALID; p_arr = bus.M_AXI_ARREADY; p_araddr = bus.M_AXI_ARADDR;
  end

  task automatic set_req(input int idx, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.req_write[idx]          = wr;
    bus.req_addr[idx*AW +: AW]  = addr;
    bus.req_wdata[idx*DW +: DW] = data;
  endtask

  task automatic drive_mask(input logic [N-1:0] mask, input int n, output int t0);
    int base;
    base = g_vec.size();
    @(posedge clk); #1;
    bus.req_valid = mask;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); #1;
      if (g_vec.size() >= base + n) break;
    end
    check_eq("grant_cnt", g_vec.size() - base, n);
    t0 = (g_vec.size() > base) ? g_cyc[base] : -1;
    @(posedge clk); #1;
    bus.req_valid = '0;
  endtask

  task automatic wait_rsp(output int busy_low);
    int base;
    base = rsp_n;
    busy_low = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); #1;
      if (rsp_n > base) break;
      if (!bus.busy) busy_low++;
    end
    check_eq("rsp_seen", rsp_n - base, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit hit before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, bl, base, aw0, w0, b0, rb;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_eq("rst_ctrl", {bus.req_ready, bus.rsp_valid, bus.busy, bus.M_AXI_AWVALID, bus.M_AXI_WVALID,
                          bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY}, 0);
    check_eq("rst_rsp", {bus.rsp_resp, bus.rsp_rdata}, 0);
    check_eq("rst_prot", {bus.M_AXI_AWPROT, bus.M_AXI_ARPROT}, 0);
    check_eq("rst_wstrb", bus.M_AXI_WSTRB, 4'hF);
    check_eq("rst_addr_data", {bus.M_AXI_AWADDR, bus.M_AXI_ARADDR, bus.M_AXI_WDATA}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single zero-wait write
    set_req(0, 1'b1, 6'h04, 32'hDEADBEEF);
    drive_mask(4'b0001, 1, t);
    wait_rsp(bl);
    check_eq("t1_grant", g_vec[g_vec.size()-1], 4'b0001);
    check_eq("t1_aw_lat", aw_cyc - t, 1);
    check_eq("t1_awaddr", aw_addr, 6'h04);
    check_eq("t1_w_lat", w_cyc - t, 1);
    check_eq("t1_wdata", w_data, 32'hDEADBEEF);
    check_eq("t1_wstrb", w_strb, 4'hF);
    check_eq("t1_rsp_lat", rsp_cyc - t, 3);
    check_eq("t1_rsp_valid", rsp_vec, 4'b0001);
    check_eq("t1_rsp_resp", rsp_resp_s, 2'b00);
    check_eq("t1_rsp_rdata", rsp_data, 0);
    @(negedge clk); #1;
    check_eq("t1_rsp_pulse", bus.rsp_valid, 0);

    // Read with three R wait cycles
    set_req(2, 1'b0, 6'h08, 32'h0);
    rdata_cfg = 32'h12345678;
    r_dly = 3;
    drive_mask(4'b0100, 1, t);
    wait_rsp(bl);
    r_dly = 0;
    check_eq("t2_araddr", ar_addr, 6'h08);
    check_eq("t2_rsp_valid", rsp_vec, 4'b0100);
    check_eq("t2_rsp_rdata", rsp_data, 32'h12345678);
    check_eq("t2_rsp_lat", rsp_cyc - t, 6);
    check_eq("t2_busy_low", bl, 0);

    reset = 1'b1;
    idle(2);
    reset = 1'b0;

    // Fairness with all four requesters held
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i * 4), 32'h0);
    base = g_vec.size();
    drive_mask(4'hF, 8, t);
    for (int k = 0; k < 8; k++) check_eq($sformatf("t3_grant%0d", k), g_vec[base+k], 4'b0001 << (k % 4));
    check_eq("t3_b2b_spacing", g_cyc[base+1] - g_cyc[base], 3);
    idle(8);

    // AW completes five cycles after W
    set_req(1, 1'b1, 6'h10, 32'hA5A50001);
    aw_dly = 5; w_dly = 0;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    drive_mask(4'b0010, 1, t);
    wait_rsp(bl);
    check_eq("t4a_skew", aw_cyc - w_cyc, 5);
    check_eq("t4a_hs_counts", {8'(aw_hs - aw0), 8'(w_hs - w0), 8'(b_hs - b0)}, 24'h010101);
    check_eq("t4a_rsp_after_b", rsp_cyc - b_cyc, 1);
    check_eq("t4a_rsp_valid", rsp_vec, 4'b0010);

    // W completes five cycles after AW
    set_req(1, 1'b1, 6'h12, 32'hA5A50002);
    aw_dly = 0; w_dly = 5;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    drive_mask(4'b0010, 1, t);
    wait_rsp(bl);
    w_dly = 0;
    check_eq("t4b_skew", w_cyc - aw_cyc, 5);
    check_eq("t4b_hs_counts", {8'(aw_hs - aw0), 8'(w_hs - w0), 8'(b_hs - b0)}, 24'h010101);
    check_eq("t4b_rsp_after_b", rsp_cyc - b_cyc, 1);
    check_eq("t4b_wdata", w_data, 32'hA5A50002);
    check_eq("t4b_awaddr", aw_addr, 6'h12);

    // SLVERR forwarded, then a normal read
    bresp_cfg = RESP_SLVERR;
    set_req(3, 1'b1, 6'h3C, 32'hCAFE0003);
    drive_mask(4'b1000, 1, t);
    wait_rsp(bl);
    bresp_cfg = RESP_OKAY;
    check_eq("t5_err_valid", rsp_vec, 4'b1000);
    check_eq("t5_err_resp", rsp_resp_s, 2'b10);
    set_req(0, 1'b0, 6'h20, 32'h0);
    rdata_cfg = 32'h0BADF00D;
    drive_mask(4'b0001, 1, t);
    wait_rsp(bl);
    check_eq("t5_ok_valid", rsp_vec, 4'b0001);
    check_eq("t5_ok_resp", rsp_resp_s, 2'b00);
    check_eq("t5_ok_rdata", rsp_data, 32'h0BADF00D);

    // Reset while ARVALID is waiting for ARREADY
    ar_dly = 20;
    set_req(2, 1'b0, 6'h14, 32'h0);
    drive_mask(4'b0100, 1, t);
    for (int k = 0; k < 10; k++) begin
      if (bus.M_AXI_ARVALID) break;
      @(negedge clk); #1;
    end
    check_eq("t6_arvalid_before", bus.M_AXI_ARVALID, 1'b1);
    rb = rsp_n;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check_eq("t6_rst_ctrl", {bus.req_ready, bus.rsp_valid, bus.busy, bus.M_AXI_AWVALID, bus.M_AXI_WVALID,
                             bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY}, 0);
    check_eq("t6_rst_rsp", {bus.rsp_resp, bus.rsp_rdata}, 0);
    check_eq("t6_rst_araddr", bus.M_AXI_ARADDR, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    ar_dly = 0;
    idle(25);
    check_eq("t6_no_rsp", rsp_n - rb, 0);
    set_req(1, 1'b0, 6'h18, 32'h0);
    set_req(3, 1'b0, 6'h1C, 32'h0);
    rdata_cfg = 32'h55AA1234;
    base = g_vec.size();
    drive_mask(4'b1010, 1, t);
    check_eq("t6_ptr_restart_grant", g_vec[base], 4'b0010);
    wait_rsp(bl);
    check_eq("t6_rsp_valid", rsp_vec, 4'b0010);
    check_eq("t6_rsp_rdata", rsp_data, 32'h55AA1234);
    check_eq("t6_araddr", ar_addr, 6'h18);

    idle(4);
    check_eq("axi_valid_stability", proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
